// File: rtl/pixel_stream_gen.sv
// Streams one frame (header, pixel thumbnail, optional Fletcher-32 pair, padding)
// as byte-swapped 16-bit words over a valid/ready handshake.
module pixel_stream_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cfg_header_words,
  input  logic [11:0] cfg_width,
  input  logic [11:0] cfg_height,
  input  logic        cfg_checksum_en,
  input  logic [15:0] cfg_padding_words,
  input  logic [15:0] cfg_pixel_initial,
  input  logic [15:0] cfg_pixel_delta,
  input  logic [3:0]  cfg_filter_period,
  input  logic [3:0]  cfg_filter_keep,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, HEADER, PIXELS, CKSUM0, CKSUM1, PAD, DONE} stateT;

  function automatic logic [15:0] byteSwap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // Adds modulo 65535; acc is always kept in 0..65534 so one subtraction suffices.
  function automatic logic [15:0] fletcherAdd(input logic [15:0] acc, input logic [15:0] d);
    logic [16:0] s;
    s = {1'b0, acc} + {1'b0, d};
    if (s >= 17'd65535) s = s - 17'd65535;
    return s[15:0];
  endfunction

  stateT       state, nextSeg, afterHdr, afterPix, afterCk, firstSeg;
  logic [7:0]  hdrWords, hdrCnt;
  logic [11:0] width, height, col, row;
  logic        ckEn;
  logic [15:0] padWords, padCnt, delta, pixVal, rowBase, sumA, sumB;
  logic [3:0]  keepK, colGrp, rowGrp;
  logic [4:0]  grpMul;

  logic        isIdle, xfer, hdrNz, pixNz, ckNz, padNz, filtOn;
  logic        hdrLast, rowEnd, pixLast, padLast, colGrpEnd, rowGrpEnd, countable;
  logic [15:0] colStepGrp, wDelta, rowStepGrp, rowBaseNxt, pixValNxt;
  logic [15:0] aCur, bCur, aNew, bNew, nextHost;

  assign isIdle = (state == IDLE);
  assign xfer   = dout_valid && dout_ready;

  // In IDLE the segment decisions come straight from the cfg inputs so the
  // first word can be loaded on the start edge itself.
  assign hdrNz = isIdle ? (cfg_header_words != 8'd0) : (hdrWords != 8'd0);
  assign pixNz = isIdle ? (cfg_width != 12'd0 && cfg_height != 12'd0)
                        : (width != 12'd0 && height != 12'd0);
  assign ckNz  = isIdle ? cfg_checksum_en : ckEn;
  assign padNz = isIdle ? (cfg_padding_words != 16'd0) : (padWords != 16'd0);

  assign afterCk  = padNz ? PAD : DONE;
  assign afterPix = ckNz ? CKSUM0 : afterCk;
  assign afterHdr = pixNz ? PIXELS : afterPix;
  assign firstSeg = hdrNz ? HEADER : afterHdr;

  assign filtOn = (cfg_filter_period != 4'd0) && (cfg_filter_keep != 4'd0) &&
                  (cfg_filter_keep <= cfg_filter_period);

  assign hdrLast   = (hdrCnt == hdrWords - 8'd1);
  assign rowEnd    = (col == width - 12'd1);
  assign pixLast   = rowEnd && (row == height - 12'd1);
  assign padLast   = (padCnt == padWords - 16'd1);
  assign colGrpEnd = (colGrp == keepK - 4'd1);
  assign rowGrpEnd = (rowGrp == keepK - 4'd1);

  // The group step past the last column of a row lands exactly on the next
  // full-image row start, which yields W*delta without dividing by K.
  assign colStepGrp = {11'd0, grpMul} * delta;
  assign wDelta     = pixVal + colStepGrp - rowBase;
  assign rowStepGrp = {11'd0, grpMul} * wDelta;
  assign rowBaseNxt = rowBase + (rowGrpEnd ? rowStepGrp : wDelta);
  assign pixValNxt  = rowEnd ? rowBaseNxt : pixVal + (colGrpEnd ? colStepGrp : delta);

  assign countable = (state == HEADER) || (state == PIXELS);
  assign aCur = isIdle ? 16'd0 : sumA;
  assign bCur = isIdle ? 16'd0 : sumB;
  assign aNew = (xfer && countable) ? fletcherAdd(aCur, byteSwap(dout)) : aCur;
  assign bNew = (xfer && countable) ? fletcherAdd(bCur, aNew) : bCur;

  always_comb begin
    nextSeg = IDLE;
    case (state)
      IDLE:    nextSeg = firstSeg;
      HEADER:  nextSeg = hdrLast ? afterHdr : HEADER;
      PIXELS:  nextSeg = pixLast ? afterPix : PIXELS;
      CKSUM0:  nextSeg = CKSUM1;
      CKSUM1:  nextSeg = afterCk;
      PAD:     nextSeg = padLast ? DONE : PAD;
      default: nextSeg = IDLE;
    endcase
  end

  always_comb begin
    nextHost = 16'd0;
    case (nextSeg)
      HEADER:  nextHost = (state == HEADER) ? {8'd0, hdrCnt + 8'd1} : 16'd0;
      PIXELS:  nextHost = (state == PIXELS) ? pixValNxt : (isIdle ? cfg_pixel_initial : pixVal);
      CKSUM0:  nextHost = aNew;
      CKSUM1:  nextHost = bNew;
      default: nextHost = 16'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;  dout <= 16'd0;  dout_valid <= 1'b0;  busy <= 1'b0;  done <= 1'b0;
      hdrWords <= 8'd0;  width <= 12'd0;  height <= 12'd0;  ckEn <= 1'b0;
      padWords <= 16'd0;  delta <= 16'd0;  keepK <= 4'd0;  grpMul <= 5'd0;
      hdrCnt <= 8'd0;  col <= 12'd0;  row <= 12'd0;  colGrp <= 4'd0;  rowGrp <= 4'd0;
      padCnt <= 16'd0;  pixVal <= 16'd0;  rowBase <= 16'd0;  sumA <= 16'd0;  sumB <= 16'd0;
    end else begin
      done <= 1'b0;
      if (isIdle) begin
        if (start) begin
          hdrWords <= cfg_header_words;  width <= cfg_width;  height <= cfg_height;
          ckEn <= cfg_checksum_en;  padWords <= cfg_padding_words;  delta <= cfg_pixel_delta;
          keepK  <= filtOn ? cfg_filter_keep : 4'd1;
          grpMul <= filtOn ? ({1'b0, cfg_filter_period} - {1'b0, cfg_filter_keep} + 5'd1) : 5'd1;
          hdrCnt <= 8'd0;  col <= 12'd0;  row <= 12'd0;  colGrp <= 4'd0;  rowGrp <= 4'd0;
          padCnt <= 16'd0;  pixVal <= cfg_pixel_initial;  rowBase <= cfg_pixel_initial;
          sumA <= 16'd0;  sumB <= 16'd0;
          busy <= 1'b1;
          state <= nextSeg;
          dout <= byteSwap(nextHost);
          dout_valid <= (nextSeg != DONE);
          done <= (nextSeg == DONE);
        end
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (xfer) begin
        sumA <= aNew;
        sumB <= bNew;
        case (state)
          HEADER: hdrCnt <= hdrCnt + 8'd1;
          PIXELS: begin
            pixVal <= pixValNxt;
            if (rowEnd) begin
              col <= 12'd0;  colGrp <= 4'd0;  row <= row + 12'd1;
              rowGrp <= rowGrpEnd ? 4'd0 : rowGrp + 4'd1;
              rowBase <= rowBaseNxt;
            end else begin
              col <= col + 12'd1;
              colGrp <= colGrpEnd ? 4'd0 : colGrp + 4'd1;
            end
          end
          PAD:     padCnt <= padCnt + 16'd1;
          default: ;
        endcase
        state <= nextSeg;
        dout <= byteSwap(nextHost);
        dout_valid <= (nextSeg != DONE);
        done <= (nextSeg == DONE);
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen: directed and random frames checked word-by-word
// against a reference model built from the frame-format rules.
module tb_pixel_stream_gen;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [7:0]  cfg_header_words;
  logic [11:0] cfg_width, cfg_height;
  logic        cfg_checksum_en;
  logic [15:0] cfg_padding_words, cfg_pixel_initial, cfg_pixel_delta;
  logic [3:0]  cfg_filter_period, cfg_filter_keep;
  logic [15:0] dout;
  logic        dout_valid, dout_ready, busy, done;
  int nChecks = 0;
  int nFails = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  pixel_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_header_words(cfg_header_words), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_checksum_en(cfg_checksum_en), .cfg_padding_words(cfg_padding_words),
    .cfg_pixel_initial(cfg_pixel_initial), .cfg_pixel_delta(cfg_pixel_delta),
    .cfg_filter_period(cfg_filter_period), .cfg_filter_keep(cfg_filter_keep),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic int effK(input int per, input int keep);
    return (per == 0 || keep == 0 || keep > per) ? 1 : keep;
  endfunction

  function automatic logic pickReady(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Expected host-order word list of a whole frame.
  task automatic buildModel(input int hdr, input int w, input int h, input int ck, input int pad,
                            input logic [15:0] init, input logic [15:0] dlt,
                            input int per, input int keep);
    int p, k, fullW, pidx, a, b;
    logic [31:0] v;
    expQ.delete();
    a = 0;
    b = 0;
    k = effK(per, keep);
    p = (k == 1 && !(per != 0 && keep == 1)) ? 1 : per;
    if (per == 0 || keep == 0 || keep > per) p = 1;
    fullW = w * p / k;
    for (int i = 0; i < hdr; i++) begin
      expQ.push_back(16'(i));
      a = (a + i) % 65535;
      b = (b + a) % 65535;
    end
    for (int r = 0; r < h; r++)
      for (int kx = 0; kx < w; kx++) begin
        pidx = ((r / k) * p + r % k) * fullW + (kx / k) * p + kx % k;
        v = 32'(init) + 32'(pidx) * 32'(dlt);
        expQ.push_back(v[15:0]);
        a = (a + int'(v[15:0])) % 65535;
        b = (b + a) % 65535;
      end
    if (ck != 0) begin
      expQ.push_back(16'(a));
      expQ.push_back(16'(b));
    end
    for (int i = 0; i < pad; i++) expQ.push_back(16'h0000);
  endtask

  task automatic runFrame(input string name, input int hdr, input int w, input int h, input int ck,
                          input int pad, input logic [15:0] init, input logic [15:0] dlt,
                          input int per, input int keep, input int readyPct, input bit midStart);
    int got = 0;
    int lastX = -1;
    bit prevStall = 0;
    bit finished = 0;
    logic [15:0] prevDout = 16'd0;
    buildModel(hdr, w, h, ck, pad, init, dlt, per, keep);
    @(posedge clk); #1;
    cfg_header_words = 8'(hdr);  cfg_width = 12'(w);  cfg_height = 12'(h);
    cfg_checksum_en = (ck != 0);  cfg_padding_words = 16'(pad);
    cfg_pixel_initial = init;  cfg_pixel_delta = dlt;
    cfg_filter_period = 4'(per);  cfg_filter_keep = 4'(keep);
    start = 1'b1;
    dout_ready = pickReady(readyPct);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk({name, "/firstValid"}, 32'(dout_valid), 32'(expQ.size() > 0));
        chk({name, "/busy"}, 32'(busy), 32'd1);
      end
      if (prevStall) begin
        chk({name, "/holdValid"}, 32'(dout_valid), 32'd1);
        chk({name, "/holdData"}, 32'(dout), 32'(prevDout));
      end
      if (done) begin
        chk({name, "/wordCount"}, 32'(got), 32'(expQ.size()));
        chk({name, "/doneLatency"}, 32'(cyc), 32'(lastX + 1));
        finished = 1;
      end else if (dout_valid && dout_ready) begin
        if (got < expQ.size())
          chk($sformatf("%s/word%0d", name, got), 32'(dout), 32'(swap16(expQ[got])));
        else
          chk({name, "/extraWord"}, 32'(dout_valid), 32'd0);
        got++;
        lastX = cyc;
      end
      prevStall = dout_valid && !dout_ready;
      prevDout = dout;
      if (!finished) begin
        @(posedge clk); #1;
        dout_ready = pickReady(readyPct);
        if (midStart) begin
          start = (cyc == 2);
          if (cyc == 2) begin
            cfg_header_words = 8'($urandom_range(0, 5));
            cfg_width = 12'($urandom_range(1, 4));
            cfg_pixel_initial = 16'($urandom);
            cfg_padding_words = 16'($urandom_range(0, 5));
          end
        end
      end
    end
    start = 1'b0;
    if (!finished) chk({name, "/timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({name, "/idleBusy"}, 32'(busy), 32'd0);
    chk({name, "/donePulse"}, 32'(done), 32'd0);
  endtask

  task automatic resetCheck(input string name);
    chk({name, "/valid"}, 32'(dout_valid), 32'd0);
    chk({name, "/busy"}, 32'(busy), 32'd0);
    chk({name, "/done"}, 32'(done), 32'd0);
    chk({name, "/dout"}, 32'(dout), 32'd0);
  endtask

  initial begin
    int k, sawDone;
    rst_n = 1'b0;  start = 1'b0;  dout_ready = 1'b1;
    cfg_header_words = '0;  cfg_width = '0;  cfg_height = '0;  cfg_checksum_en = 1'b0;
    cfg_padding_words = '0;  cfg_pixel_initial = '0;  cfg_pixel_delta = '0;
    cfg_filter_period = '0;  cfg_filter_keep = '0;
    repeat (3) @(posedge clk);
    #1;
    resetCheck("reset");
    rst_n = 1'b1;

    runFrame("noFilter", 0, 2, 1, 1, 1, 16'h0001, 16'h0001, 0, 0, 100, 0);
    runFrame("thumb", 0, 4, 2, 0, 0, 16'h0000, 16'h0001, 4, 2, 100, 0);
    runFrame("backpressure", 0, 2, 1, 1, 1, 16'h0001, 16'h0001, 0, 0, 50, 0);
    runFrame("hdrCksum", 3, 0, 0, 1, 0, 16'h0000, 16'h0001, 0, 0, 100, 0);
    runFrame("wrap", 0, 2, 1, 0, 0, 16'hFFFF, 16'h0001, 0, 0, 100, 0);
    runFrame("allZero", 0, 0, 0, 0, 0, 16'h1234, 16'h0001, 0, 0, 100, 0);
    runFrame("startBusy", 2, 6, 3, 1, 2, 16'h0100, 16'h0003, 3, 2, 70, 1);

    // Reset in the middle of the pixel segment.
    @(posedge clk); #1;
    cfg_header_words = 8'd0;  cfg_width = 12'd8;  cfg_height = 12'd4;  cfg_checksum_en = 1'b1;
    cfg_padding_words = 16'd2;  cfg_filter_period = 4'd0;  cfg_filter_keep = 4'd0;
    dout_ready = 1'b1;  start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midReset/preBusy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    resetCheck("midReset");
    rst_n = 1'b1;
    sawDone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || dout_valid) sawDone++;
    end
    chk("midReset/noResume", 32'(sawDone), 32'd0);
    runFrame("afterReset", 1, 3, 2, 1, 1, 16'h0007, 16'h0101, 5, 3, 100, 0);

    for (int n = 0; n < 20; n++) begin
      int per, keep;
      per = $urandom_range(0, 6);
      keep = $urandom_range(0, 6);
      k = effK(per, keep);
      runFrame($sformatf("rand%0d", n), $urandom_range(0, 3), k * $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2),
               16'($urandom), 16'($urandom), per, keep,
               (n % 3 == 0) ? 100 : ((n % 3 == 1) ? 70 : 40), n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end
endmodule
